// File: rtl/cgra_router_buffered_if.sv
// Flit bundle for the 5-port CGRA router; ports p=0..4 are N,E,S,W,Local, flattened at [p*W +: W].
// slave is the router side, master the fabric/testbench side.
interface cgra_router_buffered_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
);
  localparam int unsigned NP = 5;

  logic [NP*DATA_WIDTH-1:0] in_data;
  logic [NP*ADDR_WIDTH-1:0] in_dest_x;
  logic [NP*ADDR_WIDTH-1:0] in_dest_y;
  logic [NP-1:0]            in_multicast;
  logic [NP-1:0]            in_valid;
  logic [NP-1:0]            in_ready;
  logic [NP*DATA_WIDTH-1:0] out_data;
  logic [NP*ADDR_WIDTH-1:0] out_dest_x;
  logic [NP*ADDR_WIDTH-1:0] out_dest_y;
  logic [NP-1:0]            out_multicast;
  logic [NP-1:0]            out_valid;
  logic [NP-1:0]            out_ready;
  logic [NP*16-1:0]         stat_count;

  modport master (
    output in_data, in_dest_x, in_dest_y, in_multicast, in_valid, out_ready,
    input  in_ready, out_data, out_dest_x, out_dest_y, out_multicast, out_valid, stat_count
  );

  modport slave (
    input  in_data, in_dest_x, in_dest_y, in_multicast, in_valid, out_ready,
    output in_ready, out_data, out_dest_x, out_dest_y, out_multicast, out_valid, stat_count
  );
endinterface

// File: rtl/cgra_router_buffered.sv
// Buffered 5-port XY mesh router: input FIFOs, unicast/multicast fan-out, per-output round-robin.
// Optional per-output flit counters are built when ROUTER_STATS_EN is defined.
module cgra_router_buffered #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned X_COORD    = 0,
  parameter int unsigned Y_COORD    = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  cgra_router_buffered_if.slave  bus
);
  localparam int unsigned NP  = 5;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned P_N = 0;
  localparam int unsigned P_E = 1;
  localparam int unsigned P_S = 2;
  localparam int unsigned P_W = 3;
  localparam int unsigned P_L = 4;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] dx;
    logic [ADDR_WIDTH-1:0] dy;
    logic                  mc;
  } flit_t;

  flit_t         mem_q [NP][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [NP];
  logic [PW-1:0] rd_ptr_q [NP];
  logic [CW-1:0] cnt_q [NP];
  logic [NP-1:0] sent_q [NP];
  flit_t         out_flit_q [NP];
  logic [NP-1:0] out_vld_q;
  logic [2:0]    ptr_q [NP];

  flit_t         in_flit [NP];
  flit_t         head [NP];
  logic [NP-1:0] head_vld, in_rdy, wr_en, pop, free, out_load;
  logic [NP-1:0] tgt [NP];
  logic [NP-1:0] req [NP];
  logic [NP-1:0] gnt_out [NP];
  logic [NP-1:0] gnt_in [NP];
  logic [2:0]    win [NP];

  // Input side: FIFO status, head route and outstanding requests
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      in_flit[p] = '{data: bus.in_data[p*DATA_WIDTH +: DATA_WIDTH],
                     dx:   bus.in_dest_x[p*ADDR_WIDTH +: ADDR_WIDTH],
                     dy:   bus.in_dest_y[p*ADDR_WIDTH +: ADDR_WIDTH],
                     mc:   bus.in_multicast[p]};
      head[p]     = mem_q[p][rd_ptr_q[p]];
      head_vld[p] = (cnt_q[p] != '0);
      in_rdy[p]   = (cnt_q[p] != CW'(FIFO_DEPTH));
      wr_en[p]    = bus.in_valid[p] & in_rdy[p];
      if (head[p].mc)                              tgt[p] = ~(NP'(1) << p);
      else if (head[p].dx > ADDR_WIDTH'(X_COORD))  tgt[p] = NP'(1) << P_E;
      else if (head[p].dx < ADDR_WIDTH'(X_COORD))  tgt[p] = NP'(1) << P_W;
      else if (head[p].dy > ADDR_WIDTH'(Y_COORD))  tgt[p] = NP'(1) << P_S;
      else if (head[p].dy < ADDR_WIDTH'(Y_COORD))  tgt[p] = NP'(1) << P_N;
      else                                         tgt[p] = NP'(1) << P_L;
      req[p] = head_vld[p] ? (tgt[p] & ~sent_q[p]) : '0;
    end
  end

  // Per-output round-robin: first requester at or after ptr, wrapping 4 -> 0
  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    sum = '0;
    idx = '0;
    for (int o = 0; o < NP; o++) begin
      free[o]     = ~out_vld_q[o] | bus.out_ready[o];
      out_load[o] = 1'b0;
      win[o]      = '0;
      gnt_out[o]  = '0;
      if (free[o]) begin
        for (int unsigned k = 0; k < NP; k++) begin
          sum = 4'(ptr_q[o]) + 4'(k);
          idx = (sum >= 4'(NP)) ? 3'(sum - 4'(NP)) : 3'(sum);
          if (!out_load[o] && req[idx][o]) begin
            out_load[o]     = 1'b1;
            win[o]          = idx;
            gnt_out[o][idx] = 1'b1;
          end
        end
      end
    end
  end

  // A head retires once every target has been served, counting this cycle's grants
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      gnt_in[p] = '0;
      for (int o = 0; o < NP; o++) gnt_in[p][o] = gnt_out[o][p];
      pop[p] = head_vld[p] & (|gnt_in[p]) & ((sent_q[p] | gnt_in[p]) == tgt[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        wr_ptr_q[p]   <= '0;
        rd_ptr_q[p]   <= '0;
        cnt_q[p]      <= '0;
        sent_q[p]     <= '0;
        out_flit_q[p] <= '0;
        ptr_q[p]      <= '0;
      end
      out_vld_q <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (wr_en[p]) wr_ptr_q[p] <= wr_ptr_q[p] + PW'(1);
        if (pop[p])   rd_ptr_q[p] <= rd_ptr_q[p] + PW'(1);
        case ({wr_en[p], pop[p]})
          2'b10:   cnt_q[p] <= cnt_q[p] + CW'(1);
          2'b01:   cnt_q[p] <= cnt_q[p] - CW'(1);
          default: cnt_q[p] <= cnt_q[p];
        endcase
        sent_q[p] <= pop[p] ? '0 : (sent_q[p] | gnt_in[p]);
      end
      for (int o = 0; o < NP; o++) begin
        if (out_load[o]) begin
          out_flit_q[o] <= head[win[o]];
          out_vld_q[o]  <= 1'b1;
          ptr_q[o]      <= (win[o] == 3'd4) ? 3'd0 : win[o] + 3'd1;
        end else if (free[o]) begin
          out_vld_q[o]  <= 1'b0;
        end
      end
    end
  end

  // Payload storage needs no reset: occupancy lives in cnt_q
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++)
      if (wr_en[p]) mem_q[p][wr_ptr_q[p]] <= in_flit[p];
  end

  always_comb begin
    bus.in_ready  = in_rdy;
    bus.out_valid = out_vld_q;
    for (int o = 0; o < NP; o++) begin
      bus.out_data[o*DATA_WIDTH +: DATA_WIDTH]   = out_flit_q[o].data;
      bus.out_dest_x[o*ADDR_WIDTH +: ADDR_WIDTH] = out_flit_q[o].dx;
      bus.out_dest_y[o*ADDR_WIDTH +: ADDR_WIDTH] = out_flit_q[o].dy;
      bus.out_multicast[o]                       = out_flit_q[o].mc;
    end
  end

`ifdef ROUTER_STATS_EN
  logic [15:0] stat_q [NP];

  // Saturating count of completed output handshakes
  always_ff @(posedge clk) begin
    for (int o = 0; o < NP; o++) begin
      if (!rst_n)
        stat_q[o] <= '0;
      else if (out_vld_q[o] & bus.out_ready[o] & (stat_q[o] != 16'hFFFF))
        stat_q[o] <= stat_q[o] + 16'd1;
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) bus.stat_count[o*16 +: 16] = stat_q[o];
  end
`else
  always_comb bus.stat_count = '0;
`endif

endmodule
